// File: rtl/ncpu32k_dbus_resp.sv
// Data-bus responder: accepts translated DMMU requests, performs them on a
// synchronous single-port SRAM with configurable wait states, and returns one
// response per request. Faulted or out-of-range requests never touch memory.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif
`ifndef NCPU_DW
`define NCPU_DW 32
`endif

module ncpu32k_dbus_resp #(
  parameter int CONFIG_MEM_AW   = 14,
  parameter int CONFIG_MEM_WAIT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // A-channel (request from DMMU)
  output logic                      dcache_AREADY,
  input  logic                      dcache_AVALID,
  input  logic [`NCPU_AW-1:0]       dcache_AADDR,
  input  logic [`NCPU_DW/8-1:0]     dcache_AWMSK,
  input  logic [`NCPU_DW-1:0]       dcache_ADATA,
  input  logic [1:0]                dcache_AEXC,
  // B-channel (response)
  output logic                      dcache_BVALID,
  input  logic                      dcache_BREADY,
  output logic [`NCPU_DW-1:0]       dcache_BDATA,
  output logic [2:0]                dcache_BEXC,
  // SRAM port
  output logic                      mem_en,
  output logic [`NCPU_DW/8-1:0]     mem_we,
  output logic [CONFIG_MEM_AW-1:0]  mem_addr,
  output logic [`NCPU_DW-1:0]       mem_din,
  input  logic [`NCPU_DW-1:0]       mem_dout
);

  localparam int AW = `NCPU_AW;
  localparam int DW = `NCPU_DW;
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [CONFIG_MEM_AW-1:0] addr_reg;
  logic [BW-1:0]            wmsk_reg;
  logic [DW-1:0]            wdat_reg;
  logic [3:0]               wait_cnt_reg;
  logic [DW-1:0]            bdata_reg;
  logic [2:0]               bexc_reg;

  logic hs;
  logic exc;
  logic bus_err;
  logic fault;
  logic wait_done;
  logic unused_addr_lsb;

  // Byte-offset bits never select anything in a word-wide SRAM.
  assign unused_addr_lsb = ^dcache_AADDR[1:0];

  assign dcache_AREADY = (state_reg == IDLE) | ((state_reg == RESP) & dcache_BREADY);
  assign hs            = dcache_AVALID & dcache_AREADY;
  assign exc           = |dcache_AEXC;

  // Address bits above the SRAM span flag a bus error, unless the MMU already
  // faulted the request (its exception takes precedence).
  generate
    if (CONFIG_MEM_AW + 2 < AW) begin : g_bus_err
      assign bus_err = ~exc & (|dcache_AADDR[AW-1:CONFIG_MEM_AW+2]);
    end else begin : g_no_bus_err
      assign bus_err = 1'b0;
    end
  endgenerate

  assign fault     = exc | bus_err;
  assign wait_done = (wait_cnt_reg == 4'd0);

  assign dcache_BVALID = (state_reg == RESP);
  assign dcache_BDATA  = bdata_reg;
  assign dcache_BEXC   = bexc_reg;
  assign mem_addr      = addr_reg;
  assign mem_din       = wdat_reg;

  // State register; reset aborts any in-flight request without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and SRAM strobes; strobes are purely a decode of ACCESS so
  // reset removes them without waiting for a clock edge.
  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = '0;
    case (state_reg)
      IDLE: begin
        if (hs) state_next = fault ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_en     = 1'b1;
        mem_we     = wmsk_reg;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_done) state_next = RESP;
      end
      RESP: begin
        if (dcache_BREADY) begin
          if (hs) state_next = fault ? RESP : ACCESS;
          else    state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      wmsk_reg     <= '0;
      wdat_reg     <= '0;
      wait_cnt_reg <= 4'd0;
      bdata_reg    <= '0;
      bexc_reg     <= 3'b000;
    end else begin
      if (hs) begin
        addr_reg  <= dcache_AADDR[CONFIG_MEM_AW+1:2];
        wmsk_reg  <= dcache_AWMSK;
        wdat_reg  <= dcache_ADATA;
        // Non-faulted requests land here with all-zero exception bits.
        bexc_reg  <= {bus_err, dcache_AEXC};
        bdata_reg <= '0;
      end

      if (state_reg == ACCESS) begin
        wait_cnt_reg <= 4'(CONFIG_MEM_WAIT);
      end else if ((state_reg == WAIT) && !wait_done) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end

      // Writes return zero data; reads sample the SRAM on the final wait cycle.
      if ((state_reg == WAIT) && wait_done) begin
        bdata_reg <= (|wmsk_reg) ? '0 : mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_ncpu32k_dbus_resp.sv
// Directed bench: two responders (0 and 3 wait states) share one request
// stream, each backed by its own behavioural SRAM.
module tb_ncpu32k_dbus_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        avalid = 1'b0;
  logic        bready = 1'b1;
  logic [31:0] aaddr = '0;
  logic [31:0] adata = '0;
  logic [3:0]  awmsk = '0;
  logic [1:0]  aexc = '0;

  logic        aready0, bvalid0, men0;
  logic [31:0] bdata0, mdin0, mdout0;
  logic [2:0]  bexc0;
  logic [3:0]  mwe0;
  logic [13:0] maddr0;

  logic        aready3, bvalid3, men3;
  logic [31:0] bdata3, mdin3, mdout3;
  logic [2:0]  bexc3;
  logic [3:0]  mwe3;
  logic [13:0] maddr3;

  logic [31:0] mem0 [0:16383];
  logic [31:0] mem3 [0:16383];

  int checks = 0;
  int errors = 0;

  // per-transaction observations
  int          rsp0_cyc, rsp3_cyc, en0_cnt, en3_cnt, en0_cyc, en3_cyc;
  logic [31:0] rsp0_data, rsp3_data;
  logic [2:0]  rsp0_exc, rsp3_exc;
  logic [13:0] en0_addr;
  logic [3:0]  en0_we;
  bit          stable3;

  // back-to-back observations
  int          n_en, n_rsp, idx;
  int          en_c [0:2];
  int          rsp_c [0:2];
  logic [31:0] rsp_d [0:2];
  logic [31:0] b2b_addr [0:2];
  bit          rdy_ok, hs, no_resp;

  always #5 clk = ~clk;

  ncpu32k_dbus_resp #(.CONFIG_MEM_AW(14), .CONFIG_MEM_WAIT(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .dcache_AREADY(aready0), .dcache_AVALID(avalid), .dcache_AADDR(aaddr),
    .dcache_AWMSK(awmsk), .dcache_ADATA(adata), .dcache_AEXC(aexc),
    .dcache_BVALID(bvalid0), .dcache_BREADY(bready), .dcache_BDATA(bdata0),
    .dcache_BEXC(bexc0),
    .mem_en(men0), .mem_we(mwe0), .mem_addr(maddr0), .mem_din(mdin0),
    .mem_dout(mdout0)
  );

  ncpu32k_dbus_resp #(.CONFIG_MEM_AW(14), .CONFIG_MEM_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .dcache_AREADY(aready3), .dcache_AVALID(avalid), .dcache_AADDR(aaddr),
    .dcache_AWMSK(awmsk), .dcache_ADATA(adata), .dcache_AEXC(aexc),
    .dcache_BVALID(bvalid3), .dcache_BREADY(bready), .dcache_BDATA(bdata3),
    .dcache_BEXC(bexc3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_din(mdin3),
    .mem_dout(mdout3)
  );

  // SRAM behind the zero-wait responder (registered read, byte writes)
  always @(posedge clk) begin
    if (men0) begin
      for (int b = 0; b < 4; b++)
        if (mwe0[b]) mem0[maddr0][8*b +: 8] <= mdin0[8*b +: 8];
      mdout0 <= mem0[maddr0];
    end
  end

  // SRAM behind the three-wait responder
  always @(posedge clk) begin
    if (men3) begin
      for (int b = 0; b < 4; b++)
        if (mwe3[b]) mem3[maddr3][8*b +: 8] <= mdin3[8*b +: 8];
      mdout3 <= mem3[maddr3];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request (accepted by both idle responders at the next edge) and
  // watch 12 cycles; cycle 1 is the cycle after the handshake edge.
  task automatic txn(input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d, input logic [1:0] e);
    @(negedge clk);
    avalid = 1'b1; aaddr = a; awmsk = m; adata = d; aexc = e;
    @(posedge clk);
    #1 avalid = 1'b0;
    rsp0_cyc = 0; rsp3_cyc = 0; en0_cnt = 0; en3_cnt = 0; en0_cyc = 0; en3_cyc = 0;
    rsp0_data = 'x; rsp3_data = 'x; rsp0_exc = 'x; rsp3_exc = 'x;
    en0_addr = 'x; en0_we = 'x; stable3 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (men0) begin en0_cnt++; en0_cyc = k; en0_addr = maddr0; en0_we = mwe0; end
      if (men3) begin en3_cnt++; en3_cyc = k; end
      if (bvalid0 && rsp0_cyc == 0) begin rsp0_cyc = k; rsp0_data = bdata0; rsp0_exc = bexc0; end
      if (rsp3_cyc != 0 && (bvalid3 !== 1'b1 || bdata3 !== rsp3_data || bexc3 !== rsp3_exc))
        stable3 = 1'b0;
      if (bvalid3 && rsp3_cyc == 0) begin rsp3_cyc = k; rsp3_data = bdata3; rsp3_exc = bexc3; end
    end
  endtask

  initial begin
    // ---- reset values ----
    @(negedge clk);
    check("rst_aready", 32'(aready3), 32'd1);
    check("rst_bvalid", 32'(bvalid3), 32'd0);
    check("rst_bdata", bdata3, 32'h0);
    check("rst_bexc", 32'(bexc3), 32'd0);
    check("rst_mem_en", 32'(men3), 32'd0);
    check("rst_mem_we", 32'(mwe3), 32'd0);
    check("rst_mem_addr", 32'(maddr3), 32'd0);
    check("rst_mem_din", mdin3, 32'h0);
    rst_n = 1'b1;

    // ---- write 0x100 = DEADBEEF ----
    txn(32'h100, 4'hF, 32'hDEAD_BEEF, 2'b00);
    $display("txn write 0x100: w0 rsp@%0d w3 rsp@%0d", rsp0_cyc, rsp3_cyc);
    check("wr_w0_en_cyc", en0_cyc, 1);
    check("wr_w0_en_cnt", en0_cnt, 1);
    check("wr_w0_addr", 32'(en0_addr), 32'h40);
    check("wr_w0_we", 32'(en0_we), 32'hF);
    check("wr_w0_rsp_cyc", rsp0_cyc, 3);
    check("wr_w0_bdata", rsp0_data, 32'h0);
    check("wr_w0_bexc", 32'(rsp0_exc), 32'd0);
    check("wr_w3_rsp_cyc", rsp3_cyc, 6);
    check("wr_w3_en_cnt", en3_cnt, 1);

    // ---- read 0x100 ----
    txn(32'h100, 4'h0, 32'h0, 2'b00);
    $display("txn read 0x100: w0 data %h w3 data %h", rsp0_data, rsp3_data);
    check("rd_w0_rsp_cyc", rsp0_cyc, 3);
    check("rd_w0_bdata", rsp0_data, 32'hDEAD_BEEF);
    check("rd_w0_we", 32'(en0_we), 32'h0);
    check("rd_w3_rsp_cyc", rsp3_cyc, 6);
    check("rd_w3_bdata", rsp3_data, 32'hDEAD_BEEF);

    // ---- full then partial write of 0x104 ----
    txn(32'h104, 4'hF, 32'hCAFE_0104, 2'b00);
    $display("txn write 0x104 full");
    txn(32'h104, 4'b0011, 32'h1234_BEEF, 2'b00);
    $display("txn write 0x104 mask 0011");
    check("pw_w0_we", 32'(en0_we), 32'h3);

    // ---- wait-state read under back-pressure ----
    bready = 1'b0;
    txn(32'h104, 4'h0, 32'h0, 2'b00);
    $display("txn read 0x104 backpressured: w3 rsp@%0d data %h", rsp3_cyc, rsp3_data);
    check("bp_w3_en_cyc", en3_cyc, 1);
    check("bp_w3_en_cnt", en3_cnt, 1);
    check("bp_w3_rsp_cyc", rsp3_cyc, 6);
    check("bp_w3_bdata", rsp3_data, 32'hCAFE_BEEF);
    check("bp_w3_stable", 32'(stable3), 32'd1);
    check("bp_w0_bvalid_held", 32'(bvalid0), 32'd1);
    check("bp_w0_bdata_held", bdata0, 32'hCAFE_BEEF);
    check("bp_w3_aready_low", 32'(aready3), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    check("bp_w3_released", 32'(bvalid3), 32'd0);

    // ---- MMU fault on a write: no memory access ----
    txn(32'h100, 4'hF, 32'h1111_1111, 2'b10);
    $display("txn faulted write 0x100: w0 rsp@%0d bexc %b", rsp0_cyc, rsp0_exc);
    check("pf_w0_rsp_cyc", rsp0_cyc, 1);
    check("pf_w0_bexc", 32'(rsp0_exc), 32'b010);
    check("pf_w0_bdata", rsp0_data, 32'h0);
    check("pf_w0_en_cnt", en0_cnt, 0);
    check("pf_w3_rsp_cyc", rsp3_cyc, 1);
    check("pf_w3_en_cnt", en3_cnt, 0);
    txn(32'h100, 4'h0, 32'h0, 2'b00);
    $display("txn read 0x100 after fault: w0 data %h", rsp0_data);
    check("pf_old_data", rsp0_data, 32'hDEAD_BEEF);

    // ---- bus errors ----
    txn(32'h0001_0000, 4'h0, 32'h0, 2'b00);
    $display("txn read 0x10000: bexc %b", rsp0_exc);
    check("be_rsp_cyc", rsp0_cyc, 1);
    check("be_bexc", 32'(rsp0_exc), 32'b100);
    check("be_en_cnt", en0_cnt, 0);
    txn(32'h0001_0000, 4'h0, 32'h0, 2'b01);
    $display("txn read 0x10000 tlb miss: bexc %b", rsp0_exc);
    check("be_tlb_bexc", 32'(rsp0_exc), 32'b001);

    // ---- highest in-range word ----
    txn(32'h0000_FFFC, 4'hF, 32'hA5A5_5A5A, 2'b00);
    $display("txn write 0xFFFC: mem_addr %h bexc %b", en0_addr, rsp0_exc);
    check("top_addr", 32'(en0_addr), 32'h3FFF);
    check("top_bexc", 32'(rsp0_exc), 32'd0);

    // ---- back-to-back reads on the zero-wait responder ----
    b2b_addr[0] = 32'h100; b2b_addr[1] = 32'h104; b2b_addr[2] = 32'hFFFC;
    n_en = 0; n_rsp = 0; idx = 0; rdy_ok = 1'b1;
    @(negedge clk);
    avalid = 1'b1; aaddr = b2b_addr[0]; awmsk = 4'h0; aexc = 2'b00;
    for (int k = 0; k < 14; k++) begin
      if (men0) begin if (n_en < 3) en_c[n_en] = k; n_en++; end
      if (bvalid0) begin
        if (n_rsp < 3) begin rsp_c[n_rsp] = k; rsp_d[n_rsp] = bdata0; end
        n_rsp++;
        if (!aready0) rdy_ok = 1'b0;
      end
      hs = avalid & aready0;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < 3) aaddr = b2b_addr[idx];
        else avalid = 1'b0;
      end
      @(negedge clk);
    end
    avalid = 1'b0;
    $display("txn back-to-back x3: responses %0d mem_en %0d", n_rsp, n_en);
    check("b2b_en_cnt", n_en, 3);
    check("b2b_rsp_cnt", n_rsp, 3);
    check("b2b_en0", en_c[0], 1);
    check("b2b_en1", en_c[1], 4);
    check("b2b_en2", en_c[2], 7);
    check("b2b_rsp0", rsp_c[0], 3);
    check("b2b_rsp1", rsp_c[1], 6);
    check("b2b_rsp2", rsp_c[2], 9);
    check("b2b_d0", rsp_d[0], 32'hDEAD_BEEF);
    check("b2b_d1", rsp_d[1], 32'hCAFE_BEEF);
    check("b2b_d2", rsp_d[2], 32'hA5A5_5A5A);
    check("b2b_aready", 32'(rdy_ok), 32'd1);
    repeat (10) @(negedge clk);

    // ---- reset while the three-wait responder is in WAIT ----
    avalid = 1'b1; aaddr = 32'h100; awmsk = 4'h0; aexc = 2'b00;
    @(posedge clk);
    #1 avalid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rw_aready", 32'(aready3), 32'd1);
    check("rw_mem_en", 32'(men3), 32'd0);
    check("rw_bvalid", 32'(bvalid3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_resp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bvalid3 !== 1'b0) no_resp = 1'b0;
    end
    $display("txn reset during WAIT: stray response %0d", !no_resp);
    check("rw_no_resp", 32'(no_resp), 32'd1);
    txn(32'h104, 4'h0, 32'h0, 2'b00);
    $display("txn read 0x104 after reset: w3 rsp@%0d data %h", rsp3_cyc, rsp3_data);
    check("rw_after_cyc", rsp3_cyc, 6);
    check("rw_after_data", rsp3_data, 32'hCAFE_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
